// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler
// Round-robin command scheduler for an internal bank of WIDTH JK flip-flops.
// NREQ requesters post {idx, j, k} over valid/ready. Each command takes three
// cycles: IDLE (arbitrate and capture) -> DRIVE (j/k lines active) -> DONE (ack).
// Optional feature: define JK_SCHED_STATS_EN to add the toggle_cnt output, which
// counts completed in-range toggle (jk=11) commands.
module jk_bank_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int IDXW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ*2-1:0]    req_jk,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      grant,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  output logic [WIDTH-1:0]     q,
  output logic                 busy,
`ifdef JK_SCHED_STATS_EN
  output logic                 err,
  output logic [15:0]          toggle_cnt
`else
  output logic                 err
`endif
);

  localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   rr_ptr;
  logic [WW-1:0]   win;
  logic [WW-1:0]   win_nxt;
  logic            any_valid;
  logic [IDXW-1:0] lat_idx;
  logic [1:0]      lat_jk;
  logic            in_range;
  logic [NREQ-1:0] win_oh;

  // Round-robin search: scan offsets high to low so the lowest offset from
  // rr_ptr that is valid is the one left in win_nxt.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    any_valid = 1'b0;
    win_nxt   = rr_ptr;
    for (int o = NREQ - 1; o >= 0; o--) begin
      logic [WW-1:0] cand;
      cand = WW'((int'(rr_ptr) + o) % NREQ);
      if (req_valid[cand]) begin
        any_valid = 1'b1;
        win_nxt   = cand;
      end
    end
  end

  // The latched command only touches the bank when its index names a real flop.
  always_comb begin
    in_range = (int'(lat_idx) < WIDTH);
  end

  // One-hot form of the latched winner, shared by grant and req_ready.
  always_comb begin
    win_oh = '0;
    for (int r = 0; r < NREQ; r++) begin
      win_oh[r] = (win == WW'(r));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE waits for any valid, DRIVE and DONE last one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_valid) state_nxt = S_DRIVE;
      S_DRIVE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: grant in DRIVE and DONE, j/k only in DRIVE, ack/err in DONE.
  always_comb begin
    grant     = '0;
    req_ready = '0;
    j         = '0;
    k         = '0;
    err       = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_DRIVE: begin
        grant = win_oh;
        for (int b = 0; b < WIDTH; b++) begin
          if (lat_idx == IDXW'(b)) begin
            j[b] = lat_jk[1];
            k[b] = lat_jk[0];
          end
        end
      end
      S_DONE: begin
        grant     = win_oh;
        req_ready = win_oh;
        err       = ~in_range;
      end
      default: ;
    endcase
  end

  // Command capture at arbitration and RR pointer advance after the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      win     <= '0;
      lat_idx <= '0;
      lat_jk  <= '0;
    end else begin
      if (state == S_IDLE && any_valid) begin
        win     <= win_nxt;
        lat_idx <= req_idx[int'(win_nxt)*IDXW +: IDXW];
        lat_jk  <= req_jk[int'(win_nxt)*2 +: 2];
      end
      if (state == S_DONE) begin
        if (int'(win) == NREQ - 1) rr_ptr <= '0;
        else                       rr_ptr <= win + 1'b1;
      end
    end
  end

  // JK bank: the addressed flop updates at the edge that closes DRIVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (state == S_DRIVE) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (lat_idx == IDXW'(b)) begin
          case (lat_jk)
            2'b01:   q[b] <= 1'b0;
            2'b10:   q[b] <= 1'b1;
            2'b11:   q[b] <= ~q[b];
            default: q[b] <= q[b];
          endcase
        end
      end
    end
  end

`ifdef JK_SCHED_STATS_EN
  // Count completed in-range toggle commands; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_cnt <= '0;
    end else if (state == S_DONE && lat_jk == 2'b11 && in_range) begin
      toggle_cnt <= toggle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// tb_jk_bank_scheduler
// Directed bench for jk_bank_scheduler: a WIDTH=4 instance for the main
// scenarios and a WIDTH=3 instance for the out-of-range index case.
// Covers toggle_cnt as well when JK_SCHED_STATS_EN is defined.
module tb_jk_bank_scheduler;

  logic       clk = 1'b0;
  logic       reset;

  // WIDTH=4 instance
  logic [1:0] req_valid;
  logic [3:0] req_idx;
  logic [3:0] req_jk;
  logic [1:0] req_ready;
  logic [1:0] grant;
  logic [3:0] j, k, q;
  logic       busy, err;

  // WIDTH=3 instance
  logic [1:0] req_valid3;
  logic [3:0] req_idx3;
  logic [3:0] req_jk3;
  logic [1:0] req_ready3;
  logic [1:0] grant3;
  logic [2:0] j3, k3, q3;
  logic       busy3, err3;

`ifdef JK_SCHED_STATS_EN
  logic [15:0] toggle_cnt, toggle_cnt3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jk_bank_scheduler #(.WIDTH(4), .NREQ(2), .IDXW(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_jk    (req_jk),
    .req_ready (req_ready),
    .grant     (grant),
    .j         (j),
    .k         (k),
    .q         (q),
    .busy      (busy),
`ifdef JK_SCHED_STATS_EN
    .err       (err),
    .toggle_cnt(toggle_cnt)
`else
    .err       (err)
`endif
  );

  jk_bank_scheduler #(.WIDTH(3), .NREQ(2), .IDXW(2)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid3),
    .req_idx   (req_idx3),
    .req_jk    (req_jk3),
    .req_ready (req_ready3),
    .grant     (grant3),
    .j         (j3),
    .k         (k3),
    .q         (q3),
    .busy      (busy3),
`ifdef JK_SCHED_STATS_EN
    .err       (err3),
    .toggle_cnt(toggle_cnt3)
`else
    .err       (err3)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int r, input logic [1:0] idx, input logic [1:0] jk);
    req_valid[r]       = 1'b1;
    req_idx[r*2 +: 2]  = idx;
    req_jk[r*2 +: 2]   = jk;
  endtask

  // One full command on the WIDTH=4 instance with checks in DRIVE and DONE.
  task automatic run_cmd(input string tag, input int r, input logic [1:0] idx,
                         input logic [1:0] jk, input logic [3:0] exp_j,
                         input logic [3:0] exp_k, input logic [3:0] exp_q);
    logic [1:0] oh;
    oh = 2'b01 << r;
    post(r, idx, jk);
    tick();                                   // DRIVE
    check({tag, " drive j"}, 16'(j), 16'(exp_j));
    check({tag, " drive k"}, 16'(k), 16'(exp_k));
    check({tag, " drive grant"}, 16'(grant), 16'(oh));
    tick();                                   // DONE
    check({tag, " done q"}, 16'(q), 16'(exp_q));
    check({tag, " done ready"}, 16'(req_ready), 16'(oh));
    check({tag, " done jk idle"}, 16'({j, k}), 16'h0);
    req_valid[r] = 1'b0;
    tick();                                   // IDLE
    check({tag, " idle busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b11;
    req_idx    = 4'b1100;
    req_jk     = 4'b1010;
    req_valid3 = 2'b00;
    req_idx3   = '0;
    req_jk3    = '0;

    // Reset held for two cycles with valids asserted.
    repeat (2) begin
      tick();
      check("rst q", 16'(q), 16'h0);
      check("rst ready", 16'(req_ready), 16'h0);
      check("rst busy", 16'(busy), 16'h0);
      check("rst grant", 16'(grant), 16'h0);
    end
    req_valid = 2'b00;
    reset     = 1'b0;
    tick();
    check("idle busy", 16'(busy), 16'h0);
    check("idle q", 16'(q), 16'h0);

    // Single set of flop 2, then the JK table on flop 1.
    run_cmd("set2",   0, 2'd2, 2'b10, 4'b0000 | 4'b0100, 4'b0000, 4'b0100);
    run_cmd("jk10",   0, 2'd1, 2'b10, 4'b0010, 4'b0000, 4'b0110);
    run_cmd("jk11a",  0, 2'd1, 2'b11, 4'b0010, 4'b0010, 4'b0100);
    run_cmd("jk11b",  0, 2'd1, 2'b11, 4'b0010, 4'b0010, 4'b0110);
    run_cmd("jk01",   0, 2'd1, 2'b01, 4'b0000, 4'b0010, 4'b0100);
    run_cmd("jk00",   0, 2'd1, 2'b00, 4'b0000, 4'b0000, 4'b0100);
`ifdef JK_SCHED_STATS_EN
    check("toggle_cnt", toggle_cnt, 16'd2);
`endif
    // r1 clears flop 2; the RR pointer returns to 0 after serving r1.
    run_cmd("clr2_r1", 1, 2'd2, 2'b01, 4'b0000, 4'b0100, 4'b0000);

    // Contention: both valid, pointer 0 -> r0 first, then r1.
    post(0, 2'd0, 2'b10);
    post(1, 2'd3, 2'b10);
    tick();
    check("cont1 grant", 16'(grant), 16'h1);
    check("cont1 j", 16'(j), 16'h1);
    tick();
    check("cont1 ready", 16'(req_ready), 16'h1);
    check("cont1 q", 16'(q), 16'h1);
    req_valid[0] = 1'b0;
    tick();
    check("cont idle busy", 16'(busy), 16'h0);
    tick();
    check("cont2 grant", 16'(grant), 16'h2);
    check("cont2 j", 16'(j), 16'h8);
    tick();
    check("cont2 ready", 16'(req_ready), 16'h2);
    check("cont2 q", 16'(q), 16'h9);
    req_valid[1] = 1'b0;
    tick();

    // Next tie goes to r0 again; both are hold commands.
    post(0, 2'd1, 2'b00);
    post(1, 2'd2, 2'b00);
    tick();
    check("tie2 grant", 16'(grant), 16'h1);
    tick();
    check("tie2 ready", 16'(req_ready), 16'h1);
    req_valid[0] = 1'b0;
    tick();
    tick();
    check("tie2 r1 grant", 16'(grant), 16'h2);
    tick();
    check("tie2 r1 ready", 16'(req_ready), 16'h2);
    check("tie2 q", 16'(q), 16'h9);
    req_valid[1] = 1'b0;
    tick();

    // Out of range on the WIDTH=3 instance: set flop 0 first, then idx=3 jk=11.
    req_valid3[0] = 1'b1;
    req_idx3[1:0] = 2'd0;
    req_jk3[1:0]  = 2'b10;
    tick();
    tick();
    check("w3 set q", 16'(q3), 16'h1);
    req_valid3[0] = 1'b0;
    tick();
    req_valid3[0] = 1'b1;
    req_idx3[1:0] = 2'd3;
    req_jk3[1:0]  = 2'b11;
    tick();
    check("oor drive jk", 16'({j3, k3}), 16'h0);
    check("oor drive grant", 16'(grant3), 16'h1);
    check("oor drive err", 16'(err3), 16'h0);
    tick();
    check("oor err", 16'(err3), 16'h1);
    check("oor ready", 16'(req_ready3), 16'h1);
    check("oor q", 16'(q3), 16'h1);
    req_valid3[0] = 1'b0;
    tick();
    check("oor err clears", 16'(err3), 16'h0);
`ifdef JK_SCHED_STATS_EN
    check("oor toggle_cnt", toggle_cnt3, 16'd0);
`endif

    // Reset asserted during DRIVE; the command is lost, then re-posted.
    post(0, 2'd3, 2'b10);
    tick();
    check("mid drive j", 16'(j), 16'h8);
    reset = 1'b1;
    #1;
    check("mid rst q", 16'(q), 16'h0);
    check("mid rst grant", 16'(grant), 16'h0);
    check("mid rst ready", 16'(req_ready), 16'h0);
    check("mid rst busy", 16'(busy), 16'h0);
    tick();
    check("mid rst ready2", 16'(req_ready), 16'h0);
    check("mid rst q2", 16'(q), 16'h0);
    reset = 1'b0;
    tick();
    check("repost grant", 16'(grant), 16'h1);
    check("repost j", 16'(j), 16'h8);
    tick();
    check("repost ready", 16'(req_ready), 16'h1);
    check("repost q", 16'(q), 16'h8);
    req_valid[0] = 1'b0;
    tick();
    check("final busy", 16'(busy), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
